// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state encoding and default sizing for the stopwatch lap controller
package stopwatch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;
    localparam int DEF_WIDTH     = 4;
    localparam int DEF_DIV       = 2;
    localparam int DEF_LAP_DEPTH = 4;
endpackage

// File: rtl/lap_fifo.sv
// lap_fifo: first-word-fall-through FIFO of lap captures with drop detection
// Ports: clk, rst (sync, active-high); push/din write side; pop takes head when valid;
// dout head (0 when empty), valid non-empty, full at DEPTH entries, drop pulses after a rejected push.
// A push on the same edge as a pop is accepted even when full.
module lap_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [AW:0] cnt;
    logic do_pop, do_push;
    assign valid   = cnt != '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign dout    = valid ? mem[rd] : '0;
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd   <= '0;
            wr   <= '0;
            cnt  <= '0;
            drop <= 1'b0;
        end else begin
            if (do_push) wr <= wr + AW'(1);
            if (do_pop) rd <= rd + AW'(1);
            cnt  <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
            drop <= push && full && !do_pop;
        end
    end
endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: prescaled stopwatch FSM with lap snapshot register and lap FIFO
// Ports: clk, rst (sync, active-high); start/stop/lap/clear command pulses (clear > stop > start);
// counter live count; storage_counter last lap; running high in RUN;
// lap_valid/lap_data/lap_ready FWFT lap FIFO handshake; lap_full FIFO full; lap_drop lost-lap pulse.
// Define STOPWATCH_SATURATE_EN to hold the counter at its maximum instead of wrapping.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DIV       = DEF_DIV,
    parameter int LAP_DEPTH = DEF_LAP_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             lap,
    input  logic             clear,
    output logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] storage_counter,
    output logic             running,
    output logic             lap_valid,
    output logic [WIDTH-1:0] lap_data,
    input  logic             lap_ready,
    output logic             lap_full,
    output logic             lap_drop
);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    state_t state, state_n;
    logic [PW-1:0] presc;
    logic [WIDTH-1:0] cnt_inc;
    logic adv, lap_take;
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    always_comb begin
        state_n  = clear ? IDLE
                 : (stop && state == RUN) ? PAUSE
                 : (start && !stop && state != RUN) ? RUN
                 : state;
        // a stop on the terminal prescale edge freezes the phase, so no count is gained or lost
        adv      = state == RUN && !stop && !clear;
        lap_take = lap && state != IDLE && !clear;
    end
    assign running = state == RUN;
`ifdef STOPWATCH_SATURATE_EN
    assign cnt_inc = (counter == '1) ? counter : counter + WIDTH'(1);
`else
    assign cnt_inc = counter + WIDTH'(1);
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            counter         <= '0;
            presc           <= '0;
            storage_counter <= '0;
        end else if (clear) begin
            counter <= '0;
            presc   <= '0;
        end else begin
            if (adv) presc <= (presc == PMAX) ? '0 : presc + PW'(1);
            if (adv && presc == PMAX) counter <= cnt_inc;
            if (lap_take) storage_counter <= counter;
        end
    end
    lap_fifo #(.W(WIDTH), .DEPTH(LAP_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lap_take),
        .pop   (lap_ready),
        .din   (counter),
        .dout  (lap_data),
        .valid (lap_valid),
        .full  (lap_full),
        .drop  (lap_drop)
    );
endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb_stopwatch_lap_ctrl: directed and randomized checks of stopwatch_lap_ctrl against a queue-based model
module tb_stopwatch_lap_ctrl;
    localparam int W     = 4;
    localparam int D     = 2;
    localparam int DEPTH = 4;
    localparam int MAXV  = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, stop = 1'b0, lap = 1'b0, clear = 1'b0, lap_ready = 1'b0;
    logic [W-1:0] counter, storage_counter, lap_data;
    logic running, lap_valid, lap_full, lap_drop;

    int checks = 0;
    int errors = 0;

    // reference model: mode 0 idle, 1 run, 2 pause
    int m_mode, m_pre, m_cnt, m_store;
    bit m_drop;
    int q[$];

    always #5 clk = ~clk;

    stopwatch_lap_ctrl #(.WIDTH(W), .DIV(D), .LAP_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .lap             (lap),
        .clear           (clear),
        .counter         (counter),
        .storage_counter (storage_counter),
        .running         (running),
        .lap_valid       (lap_valid),
        .lap_data        (lap_data),
        .lap_ready       (lap_ready),
        .lap_full        (lap_full),
        .lap_drop        (lap_drop)
    );

    task automatic do_reset();
        rst = 1'b1; start = 1'b1; stop = 1'b0; lap = 1'b1; clear = 1'b0; lap_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; lap = 1'b0; lap_ready = 1'b0;
        m_mode = 0; m_pre = 0; m_cnt = 0; m_store = 0; m_drop = 1'b0;
        q.delete();
    endtask

    task automatic cyc(input bit s, input bit p, input bit l, input bit c, input bit r);
        bit pop, take, was_full;
        start = s; stop = p; lap = l; clear = c; lap_ready = r;
        @(posedge clk);
        pop      = q.size() > 0 && r;
        take     = l && m_mode != 0 && !c;
        was_full = q.size() == DEPTH;
        m_drop   = take && was_full && !pop;
        if (pop) void'(q.pop_front());
        if (take && !m_drop) q.push_back(m_cnt);
        if (take) m_store = m_cnt;
        if (c) begin
            m_mode = 0; m_cnt = 0; m_pre = 0;
        end else begin
            if (m_mode == 1 && !p) begin
                m_pre++;
                if (m_pre == D) begin
                    m_pre = 0;
`ifdef STOPWATCH_SATURATE_EN
                    m_cnt = (m_cnt == MAXV) ? MAXV : m_cnt + 1;
`else
                    m_cnt = (m_cnt + 1) % (MAXV + 1);
`endif
                end
            end
            if (p && m_mode == 1) m_mode = 2;
            else if (s && !p && m_mode != 1) begin
                if (m_mode == 0) m_pre = 0;
                m_mode = 1;
            end
        end
        #1;
    endtask

    task automatic advance_to(input int k);
        int guard = 0;
        while (m_cnt != k && guard < 200) begin
            cyc(0, 0, 0, 0, 0);
            guard++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({counter, storage_counter, lap_data} !== '0 || {running, lap_valid, lap_full, lap_drop} !== 4'b0) begin
            errors++;
            $display("FAIL reset: cnt=%0d store=%0d data=%0d run=%b v=%b full=%b drop=%b want all 0",
                     counter, storage_counter, lap_data, running, lap_valid, lap_full, lap_drop);
        end
    endtask

    task automatic test_count_timing();
        int exp_c[5] = '{0, 0, 1, 1, 2};
        do_reset();
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL start_running: got %b want 1", running);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc(0, 0, 0, 0, 0);
            checks++;
            if (counter !== W'(exp_c[i])) begin
                errors++;
                $display("FAIL count_timing[%0d]: got %0d want %0d", i, counter, exp_c[i]);
            end
        end
    endtask

    task automatic test_wrap();
        advance_to(MAXV);
        checks++;
        if (counter !== W'(MAXV)) begin
            errors++;
            $display("FAIL reach_max: got %0d want %0d", counter, MAXV);
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        checks++;
`ifdef STOPWATCH_SATURATE_EN
        if (counter !== W'(MAXV)) begin
            errors++;
            $display("FAIL saturate: got %0d want %0d", counter, MAXV);
        end
`else
        if (counter !== '0) begin
            errors++;
            $display("FAIL wrap: got %0d want 0", counter);
        end
`endif
    endtask

    task automatic test_start_stop_together();
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        checks++;
        if (running !== 1'b0 || counter !== W'(1)) begin
            errors++;
            $display("FAIL start_stop: run=%b cnt=%0d want run=0 cnt=1", running, counter);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (running !== 1'b1 || counter !== W'(1)) begin
            errors++;
            $display("FAIL resume: run=%b cnt=%0d want run=1 cnt=1", running, counter);
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (counter !== W'(2)) begin
            errors++;
            $display("FAIL resume_phase: got %0d want 2", counter);
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (counter !== W'(2)) begin
            errors++;
            $display("FAIL resume_no_extra: got %0d want 2", counter);
        end
    endtask

    task automatic test_lap_overflow();
        do_reset();
        cyc(1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            advance_to(k);
            cyc(0, 0, 1, 0, 0);
            checks++;
            if (storage_counter !== W'(k) || lap_full !== (k >= 4) || lap_drop !== (k == 5)) begin
                errors++;
                $display("FAIL lap%0d: store=%0d full=%b drop=%b want store=%0d full=%b drop=%b",
                         k, storage_counter, lap_full, lap_drop, k, k >= 4, k == 5);
            end
        end
        cyc(0, 1, 0, 0, 0);
        checks++;
        if (lap_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_one_cycle: got %b want 0", lap_drop);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (lap_valid !== 1'b1 || lap_data !== W'(i)) begin
                errors++;
                $display("FAIL drain%0d: v=%b data=%0d want v=1 data=%0d", i, lap_valid, lap_data, i);
            end
            cyc(0, 0, 0, 0, 1);
        end
        checks++;
        if (lap_valid !== 1'b0 || lap_full !== 1'b0) begin
            errors++;
            $display("FAIL drained: v=%b full=%b want 0 0", lap_valid, lap_full);
        end
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (lap_valid !== 1'b0 || lap_data !== '0) begin
            errors++;
            $display("FAIL pop_empty: v=%b data=%0d want 0 0", lap_valid, lap_data);
        end
    endtask

    task automatic test_full_push_pop();
        int exp_d[4] = '{2, 3, 4, 6};
        do_reset();
        cyc(1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            advance_to(k);
            cyc(0, 0, 1, 0, 0);
        end
        advance_to(6);
        cyc(0, 0, 1, 0, 1);
        checks++;
        if (lap_drop !== 1'b0 || lap_full !== 1'b1 || lap_data !== W'(2)) begin
            errors++;
            $display("FAIL full_push_pop: drop=%b full=%b data=%0d want 0 1 2", lap_drop, lap_full, lap_data);
        end
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lap_data !== W'(exp_d[i])) begin
                errors++;
                $display("FAIL tail_drain%0d: got %0d want %0d", i, lap_data, exp_d[i]);
            end
            cyc(0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_clear_with_lap();
        do_reset();
        cyc(1, 0, 0, 0, 0);
        advance_to(1);
        cyc(0, 0, 1, 0, 0);
        advance_to(7);
        cyc(0, 0, 1, 1, 0);
        checks++;
        if (counter !== '0 || running !== 1'b0 || storage_counter !== W'(1) ||
            lap_valid !== 1'b1 || lap_data !== W'(1) || lap_full !== 1'b0) begin
            errors++;
            $display("FAIL clear_lap: cnt=%0d run=%b store=%0d v=%b data=%0d full=%b want 0 0 1 1 1 0",
                     counter, running, storage_counter, lap_valid, lap_data, lap_full);
        end
        cyc(0, 0, 1, 0, 0);
        checks++;
        if (storage_counter !== W'(1) || lap_full !== 1'b0) begin
            errors++;
            $display("FAIL idle_lap: store=%0d full=%b want 1 0", storage_counter, lap_full);
        end
        cyc(1, 0, 0, 0, 0);
        advance_to(3);
        cyc(0, 0, 1, 0, 0);
        do_reset();
        checks++;
        if (lap_valid !== 1'b0 || counter !== '0 || running !== 1'b0 || storage_counter !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: v=%b cnt=%0d run=%b store=%0d want 0 0 0 0",
                     lap_valid, counter, running, storage_counter);
        end
    endtask

    task automatic test_random();
        bit s, p, l, c, r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s = $urandom_range(99) < 20;
            p = $urandom_range(99) < 8;
            l = $urandom_range(99) < 25;
            c = $urandom_range(99) < 2;
            r = $urandom_range(99) < 30;
            cyc(s, p, l, c, r);
            checks++;
            if (counter !== W'(m_cnt) || storage_counter !== W'(m_store) || running !== (m_mode == 1) ||
                lap_valid !== (q.size() > 0) || lap_data !== W'(q.size() > 0 ? q[0] : 0) ||
                lap_full !== (q.size() == DEPTH) || lap_drop !== m_drop) begin
                errors++;
                $display("FAIL random@%0d: cnt=%0d/%0d store=%0d/%0d run=%b/%b v=%b/%b data=%0d full=%b drop=%b/%b",
                         i, counter, m_cnt, storage_counter, m_store, running, m_mode == 1,
                         lap_valid, q.size() > 0, lap_data, lap_full, lap_drop, m_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_timing();
        test_wrap();
        test_start_stop_together();
        test_lap_overflow();
        test_full_push_pop();
        test_clear_with_lap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_lap_ctrl.md
# stopwatch_lap_ctrl

Controller that sequences a synchronous up-counter and its snapshot (lap) register from single-cycle start, stop, lap and clear commands. It adds a small FIFO of lap captures drained through a valid/ready handshake. It sits between user command logic and the 4-bit counter/storage datapath, and replaces free-running ripple clocking with a prescaled enable on one clock.

## Interface
- WIDTH, 4: counter, snapshot and lap-entry width.
- DIV, 2: prescale ratio, clk cycles per count in RUN; legal range is 1 or more.
- LAP_DEPTH, 4: lap FIFO entries; a power of two, 2 or more.
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command pulse: begin or resume counting.
- stop  in  1  command pulse: pause counting.
- lap  in  1  command pulse: capture counter into snapshot and FIFO.
- clear  in  1  command pulse: return to IDLE with counter zeroed.
- counter  out  WIDTH  live count.
- storage_counter  out  WIDTH  most recent lap capture.
- running  out  1  high in RUN.
- lap_valid  out  1  FIFO non-empty.
- lap_data  out  WIDTH  FIFO head, first-word-fall-through.
- lap_ready  in  1  consumer accepts head when lap_valid is also high.
- lap_full  out  1  FIFO holds LAP_DEPTH entries.
- lap_drop  out  1  one-cycle pulse: lap lost because FIFO was full.

## Operation
- States: IDLE, RUN, PAUSE.
- IDLE to RUN on start.
- RUN to PAUSE on stop.
- PAUSE to RUN on start.
- Any state to IDLE on clear.
- Command priority: clear > stop > start.
  - start and stop in the same cycle: stop wins (RUN goes to PAUSE; IDLE and PAUSE stay put).
- clear zeroes counter and prescaler. It does not flush the FIFO and does not change storage_counter.
- Prescaler counts only in RUN, 0..DIV-1.
  - When it is at DIV-1, counter increments and prescaler returns to 0.
  - PAUSE holds the prescaler value, so resume is phase-exact.
  - Entering RUN from IDLE starts the prescaler at 0.
- Counter wraps from 2^WIDTH-1 to 0 (see Configuration).
- lap in RUN or PAUSE:
  - storage_counter takes the current counter value, which is the pre-increment value if an increment happens in the same cycle.
  - The same value is pushed to the FIFO.
- lap in IDLE is ignored, including the cycle in which clear is asserted.
- FIFO full on lap:
  - If there is no pop in the same cycle, the push is discarded, lap_drop pulses and storage_counter still updates.
  - If a pop (lap_valid and lap_ready) happens in the same cycle, the push is accepted and there is no drop.
- Pop on empty has no effect.
- Reset values: state IDLE; counter, storage_counter, running, lap_valid, lap_data, lap_full and lap_drop are all 0; prescaler 0; FIFO empty.
- Reset wins over every command.
- Reset mid-operation discards FIFO contents.

## Timing
- Commands are sampled at a clk edge and take effect on that edge; running follows in the next cycle.
- start sampled at edge t from IDLE: counter reads 1 after edge t+DIV, 2 after t+2·DIV.
- With DIV=1, counter increments on every RUN cycle.
- stop sampled on the edge where the prescaler is at DIV-1: no increment occurs.
- lap sampled at edge t:
  - storage_counter is valid after t.
  - With the FIFO empty, lap_valid rises after t with lap_data equal to the captured value.
- Pop at edge t: the next entry appears on lap_data after t, or lap_valid falls if none remain.
- lap_full and lap_valid are registered and reflect the post-edge occupancy.
- lap_drop is high for exactly the cycle after the dropped lap edge.

## Configuration
- STOPWATCH_SATURATE_EN defined: counter holds at 2^WIDTH-1 in RUN instead of wrapping.
  - The prescaler keeps cycling.
  - clear still zeroes the counter.
- STOPWATCH_SATURATE_EN undefined: modulo-2^WIDTH wrap.

## Structure
- Shared package stopwatch_pkg holds:
  - the state enum typedef (IDLE, RUN, PAUSE) with explicit 2-bit encodings 00, 01, 10;
  - the default WIDTH, DIV and LAP_DEPTH constants.
- Sub-module lap_fifo provides:
  - a parameterised FWFT FIFO with push/pop/full/empty and drop detection;
  - a simultaneous push+pop at full counted as accepted.
- The top holds the FSM, prescaler, counter and snapshot register.

## Test plan
- Reset with default parameters, start at t: counter is 0 after t+1, 1 after t+2, 2 after t+4; running is 1 after t.
- RUN at count 15 then wrap: without the macro, counter 15 → 0; with STOPWATCH_SATURATE_EN, it stays at 15.
- start and stop together in RUN: state goes to PAUSE. Later start: counting resumes with the preserved prescaler phase and no lost or extra count.
- Five laps at counts 1,2,3,4,5 with lap_ready=0 and LAP_DEPTH=4:
  - lap_full rises after the 4th lap;
  - the 5th lap pulses lap_drop and sets storage_counter=5;
  - draining returns 1,2,3,4.
- FIFO full with lap and lap_ready in the same cycle: no lap_drop, occupancy stays 4, and the new value becomes the tail.
- clear asserted together with lap in RUN at count 7:
  - counter becomes 0 and state becomes IDLE;
  - lap is ignored, so storage_counter and the FIFO are unchanged;
  - rst mid-RUN empties the FIFO.
